// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 8088 bus-cycle front end.
// Holds the cycle state encoding, wait-counter width and strobe levels.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CMD  = 2'd2
  } bus_state_t;

  localparam int WAIT_W = 4;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state down-counter: loadable, decrements on request, saturates at zero.
// 'last' flags the final wait cycle so READY can be registered high on time.
module bus_wait_timer
  import cpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec_en,
  output logic [WAIT_W-1:0] cnt,
  output logic              last
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q <= WAIT_W'(1));

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 8088 bus-cycle front end: latches the muxed address on ALE, registers the
// strobes and write data onto the system bus, and holds READY low for wait states.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ale,
  input  logic [7:0]  cpu_ad,
  input  logic [11:0] cpu_a_hi,
  input  logic        cpu_iom,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_inta_n,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rd_data,
  output logic [19:0] bus_addr,
  output logic        bus_iom,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_inta_n,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_err,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_wait_cnt
);

  if ((MEM_WAIT < 0) || (MEM_WAIT > 15) || (IO_WAIT < 0) || (IO_WAIT > 15)) begin : g_param_check
    $error("cpu_bus_ctrl: MEM_WAIT and IO_WAIT must be within 0..15");
  end

  localparam logic [WAIT_W-1:0] MEM_W = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_W  = WAIT_W'(IO_WAIT);

  bus_state_t        state_q, state_d;
  logic [19:0]       addr_q, addr_d;
  logic              iom_q, iom_d;
  logic [7:0]        dout_q, dout_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              inta_n_q, inta_n_d;
  logic              ready_q, ready_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              err_q, err_d;

  logic              timer_load;
  logic [WAIT_W-1:0] timer_val;
  logic              timer_dec;
  logic [WAIT_W-1:0] timer_cnt;
  logic              timer_last;

  // Active-high view of the CPU strobes, ordered {rd, wr, inta}.
  logic [2:0] strb_act;
  logic       strb_any;
  logic       strb_multi;

  assign strb_act   = {~cpu_rd_n, ~cpu_wr_n, ~cpu_inta_n};
  assign strb_any   = (strb_act != 3'b000);
  assign strb_multi = ((strb_act & (strb_act - 3'd1)) != 3'b000);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iom_d      = iom_q;
    dout_d     = dout_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    inta_n_d   = inta_n_q;
    ready_d    = ready_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_val  = MEM_W;
    timer_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_ale) begin
          addr_d  = {cpu_a_hi, cpu_ad};
          iom_d   = cpu_iom;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (cpu_ale) begin
          addr_d = {cpu_a_hi, cpu_ad};
          iom_d  = cpu_iom;
        end else if (strb_multi) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (strb_any) begin
          rd_n_d     = cpu_rd_n;
          wr_n_d     = cpu_wr_n;
          inta_n_d   = cpu_inta_n;
          if (!cpu_wr_n) begin
            dout_d = cpu_ad;
          end
          // INTA is timed like an I/O cycle whatever IO/M says.
          timer_val  = (iom_q || !cpu_inta_n) ? IO_W : MEM_W;
          timer_load = 1'b1;
          ready_d    = (timer_val == '0);
          state_d    = CMD;
        end
      end

      CMD: begin
        timer_dec = 1'b1;
        if (!rd_n_q || !inta_n_q) begin
          rd_data_d = bus_din;
        end
        if (cpu_ale || !strb_any) begin
          err_d    = err_q | cpu_ale;
          rd_n_d   = STROBE_OFF;
          wr_n_d   = STROBE_OFF;
          inta_n_d = STROBE_OFF;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          ready_d = timer_last;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      iom_q     <= 1'b0;
      dout_q    <= '0;
      rd_n_q    <= STROBE_OFF;
      wr_n_q    <= STROBE_OFF;
      inta_n_q  <= STROBE_OFF;
      ready_q   <= 1'b1;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iom_q     <= iom_d;
      dout_q    <= dout_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      inta_n_q  <= inta_n_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  bus_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec_en   (timer_dec),
    .cnt      (timer_cnt),
    .last     (timer_last)
  );

  assign cpu_ready    = ready_q;
  assign cpu_rd_data  = rd_data_q;
  assign bus_addr     = addr_q;
  assign bus_iom      = iom_q;
  assign bus_rd_n     = rd_n_q;
  assign bus_wr_n     = wr_n_q;
  assign bus_inta_n   = inta_n_q;
  assign bus_dout     = dout_q;
  assign bus_err      = err_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = timer_cnt;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: two instances with different wait counts share one
// CPU-side stimulus; per-instance monitors check each bus cycle against a model.
module tb_cpu_bus_ctrl;
  import cpu_bus_pkg::*;

  localparam int N = 2;
  localparam int MEM_W0 = 0;
  localparam int IO_W0  = 2;
  localparam int MEM_W1 = 3;
  localparam int IO_W1  = 5;

  localparam int K_RD = 0, K_WR = 1, K_INTA = 2;
  localparam int AB_NONE = 0, AB_ALE = 1, AB_RST = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_ale;
  logic [7:0]  cpu_ad;
  logic [11:0] cpu_a_hi;
  logic        cpu_iom;
  logic        cpu_rd_n, cpu_wr_n, cpu_inta_n;
  logic [7:0]  bus_din;

  logic        cpu_ready    [N];
  logic [7:0]  cpu_rd_data  [N];
  logic [19:0] bus_addr     [N];
  logic        bus_iom      [N];
  logic        bus_rd_n     [N];
  logic        bus_wr_n     [N];
  logic        bus_inta_n   [N];
  logic [7:0]  bus_dout     [N];
  logic        bus_err      [N];
  logic [1:0]  dbg_state    [N];
  logic [3:0]  dbg_wait_cnt [N];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [19:0] addr;
    logic        iom;
    logic [2:0]  strb;       // expected active strobe, {rd, wr, inta}
    logic [7:0]  dout;
    logic [7:0]  low_cycles;
    logic [7:0]  ready_low;
    logic [7:0]  rd_data;
    logic [19:0] addr_end;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  // Reference model state shared by both instances.
  logic [7:0] m_rd;
  logic [7:0] m_dout;
  logic       m_err;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d: actual 0x%0h required 0x%0h at %0t", name, g, act, req, $time);
    end
  endtask

  function automatic int mem_w(input int g);
    return (g == 0) ? MEM_W0 : MEM_W1;
  endfunction

  function automatic int io_w(input int g);
    return (g == 0) ? IO_W0 : IO_W1;
  endfunction

  function automatic int q_size(input int g);
    return (g == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t pop_exp(input int g);
    if (g == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // ---------------- DUTs and monitors ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    cpu_bus_ctrl #(
      .MEM_WAIT ((g == 0) ? MEM_W0 : MEM_W1),
      .IO_WAIT  ((g == 0) ? IO_W0  : IO_W1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_ale      (cpu_ale),
      .cpu_ad       (cpu_ad),
      .cpu_a_hi     (cpu_a_hi),
      .cpu_iom      (cpu_iom),
      .cpu_rd_n     (cpu_rd_n),
      .cpu_wr_n     (cpu_wr_n),
      .cpu_inta_n   (cpu_inta_n),
      .cpu_ready    (cpu_ready[g]),
      .cpu_rd_data  (cpu_rd_data[g]),
      .bus_addr     (bus_addr[g]),
      .bus_iom      (bus_iom[g]),
      .bus_rd_n     (bus_rd_n[g]),
      .bus_wr_n     (bus_wr_n[g]),
      .bus_inta_n   (bus_inta_n[g]),
      .bus_dout     (bus_dout[g]),
      .bus_din      (bus_din),
      .bus_err      (bus_err[g]),
      .dbg_state    (dbg_state[g]),
      .dbg_wait_cnt (dbg_wait_cnt[g])
    );

    logic       active    = 1'b0;
    logic       cur_valid = 1'b0;
    exp_t       cur;
    int         low_cnt;
    int         rdy_low;
    logic [2:0] s_now;

    always @(negedge clk) begin
      if (mon_en) begin
        s_now = {~bus_rd_n[g], ~bus_wr_n[g], ~bus_inta_n[g]};
        if (!active) begin
          if (s_now != 3'b000) begin
            active  = 1'b1;
            low_cnt = 1;
            rdy_low = (cpu_ready[g] !== 1'b1) ? 1 : 0;
            if (q_size(g) == 0) begin
              cur_valid = 1'b0;
              check("strobe_without_cycle", g, 32'(s_now), 32'd0);
            end else begin
              cur_valid = 1'b1;
              cur = pop_exp(g);
              check("bus_addr", g, 32'(bus_addr[g]), 32'(cur.addr));
              check("bus_iom", g, 32'(bus_iom[g]), 32'(cur.iom));
              check("strobe_kind", g, 32'(s_now), 32'(cur.strb));
              check("bus_dout", g, 32'(bus_dout[g]), 32'(cur.dout));
            end
          end else begin
            check("ready_idle", g, 32'(cpu_ready[g]), 32'd1);
          end
        end else if (s_now != 3'b000) begin
          low_cnt++;
          if (cpu_ready[g] !== 1'b1) rdy_low++;
        end else begin
          active = 1'b0;
          if (cur_valid) begin
            check("strobe_width", g, 32'(low_cnt), 32'(cur.low_cycles));
            check("ready_low_cycles", g, 32'(rdy_low), 32'(cur.ready_low));
            check("cpu_rd_data", g, 32'(cpu_rd_data[g]), 32'(cur.rd_data));
            check("addr_after_cycle", g, 32'(bus_addr[g]), 32'(cur.addr_end));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind, input logic [19:0] addr, input logic iom,
                          input logic [7:0] wdata, input logic [7:0] din,
                          input int hold, input int abort, input int at);
    exp_t e;
    int   w;
    int   end_c;
    for (int g = 0; g < N; g++) begin
      w     = (iom || (kind == K_INTA)) ? io_w(g) : mem_w(g);
      end_c = (abort == AB_NONE) ? hold : at;
      e.addr       = addr;
      e.iom        = iom;
      e.strb       = (kind == K_RD) ? 3'b100 : (kind == K_WR) ? 3'b010 : 3'b001;
      e.dout       = (kind == K_WR) ? wdata : m_dout;
      e.low_cycles = 8'(end_c);
      e.ready_low  = 8'((w < end_c) ? w : end_c);
      e.rd_data    = (abort == AB_RST) ? 8'h00 : (kind != K_WR) ? din : m_rd;
      e.addr_end   = (abort == AB_RST) ? 20'h0 : addr;
      if (g == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    if (abort == AB_RST) begin
      m_rd   = 8'h00;
      m_dout = 8'h00;
      m_err  = 1'b0;
    end else begin
      if (kind == K_WR) m_dout = wdata;
      else              m_rd   = din;
      if (abort == AB_ALE) m_err = 1'b1;
    end
  endtask

  task automatic check_reset_vals();
    for (int g = 0; g < N; g++) begin
      check("rst_bus_addr", g, 32'(bus_addr[g]), 32'd0);
      check("rst_bus_iom", g, 32'(bus_iom[g]), 32'd0);
      check("rst_bus_dout", g, 32'(bus_dout[g]), 32'd0);
      check("rst_strobes", g, 32'({bus_rd_n[g], bus_wr_n[g], bus_inta_n[g]}), 32'h7);
      check("rst_cpu_ready", g, 32'(cpu_ready[g]), 32'd1);
      check("rst_cpu_rd_data", g, 32'(cpu_rd_data[g]), 32'd0);
      check("rst_bus_err", g, 32'(bus_err[g]), 32'd0);
      check("rst_state", g, 32'(dbg_state[g]), 32'(IDLE));
      check("rst_wait_cnt", g, 32'(dbg_wait_cnt[g]), 32'd0);
    end
  endtask

  task automatic check_err();
    for (int g = 0; g < N; g++) check("bus_err", g, 32'(bus_err[g]), 32'(m_err));
  endtask

  task automatic do_txn(input int kind, input logic [19:0] addr, input logic iom,
                        input logic [7:0] wdata, input logic [7:0] din,
                        input int hold, input int abort, input int at, input int gap);
    cpu_ale  = 1'b1;
    cpu_a_hi = addr[19:8];
    cpu_ad   = addr[7:0];
    cpu_iom  = iom;
    tick();
    cpu_ale = 1'b0;
    cpu_ad  = wdata;
    bus_din = din;
    repeat (gap) tick();
    push_exp(kind, addr, iom, wdata, din, hold, abort, at);
    cpu_rd_n   = (kind == K_RD)   ? 1'b0 : 1'b1;
    cpu_wr_n   = (kind == K_WR)   ? 1'b0 : 1'b1;
    cpu_inta_n = (kind == K_INTA) ? 1'b0 : 1'b1;
    tick();
    for (int i = 1; i < hold; i++) begin
      if ((abort == AB_ALE) && (i == at)) begin
        cpu_ale  = 1'b1;
        cpu_a_hi = ~addr[19:8];
        cpu_ad   = ~addr[7:0];
      end
      if ((abort == AB_RST) && (i == at)) rst = 1'b1;
      tick();
      if ((abort == AB_RST) && (i == at)) check_reset_vals();
      cpu_ale = 1'b0;
      rst     = 1'b0;
    end
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_inta_n = 1'b1;
    tick();
    tick();
    check_err();
  endtask

  task automatic do_double_strobe(input logic [19:0] addr, input logic iom);
    cpu_ale  = 1'b1;
    cpu_a_hi = addr[19:8];
    cpu_ad   = addr[7:0];
    cpu_iom  = iom;
    tick();
    cpu_ale  = 1'b0;
    cpu_rd_n = 1'b0;
    cpu_wr_n = 1'b0;
    tick();
    tick();
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    m_err    = 1'b1;
    tick();
    tick();
    check_err();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    cpu_ale    = 1'b0;
    cpu_ad     = 8'h00;
    cpu_a_hi   = 12'h000;
    cpu_iom    = 1'b0;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_inta_n = 1'b1;
    bus_din    = 8'h00;
    m_rd       = 8'h00;
    m_dout     = 8'h00;
    m_err      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals();
    mon_en = 1'b1;
    tick();

    do_txn(K_RD,   20'hFC012, 1'b0, 8'h00, 8'hA5, 3, AB_NONE, 0, 0);
    do_txn(K_WR,   20'h00021, 1'b1, 8'h13, 8'h00, 4, AB_NONE, 0, 1);
    do_txn(K_INTA, 20'h00000, 1'b0, 8'h00, 8'h08, 7, AB_NONE, 0, 0);
    do_double_strobe(20'h12345, 1'b0);
    do_txn(K_RD,   20'h54321, 1'b0, 8'h00, 8'h3C, 5, AB_NONE, 0, 0);
    do_txn(K_RD,   20'hABCDE, 1'b0, 8'h00, 8'h77, 6, AB_ALE, 2, 0);
    do_txn(K_RD,   20'h00300, 1'b1, 8'h00, 8'h5A, 8, AB_RST, 3, 0);

    for (int t = 0; t < 60; t++) begin
      int          kind, hold, abort, at, sel;
      logic [19:0] addr;
      kind  = int'($urandom_range(2, 0));
      addr  = 20'($urandom);
      hold  = int'($urandom_range(8, 1));
      sel   = int'($urandom_range(99, 0));
      abort = AB_NONE;
      at    = 0;
      if (sel < 6) begin
        do_double_strobe(addr, 1'($urandom));
      end else begin
        if ((sel < 18) && (hold >= 2)) begin
          abort = AB_ALE;
          at    = int'($urandom_range(hold - 1, 1));
        end else if ((sel < 24) && (hold >= 2)) begin
          abort = AB_RST;
          at    = int'($urandom_range(hold - 1, 1));
        end
        do_txn(kind, addr, 1'($urandom), 8'($urandom), 8'($urandom), hold, abort, at,
               int'($urandom_range(2, 0)));
      end
    end

    repeat (5) tick();
    for (int g = 0; g < N; g++) check("pending_cycles", g, 32'(q_size(g)), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Synchronous 8088 bus-cycle front end between the soft CPU pins and the system bus decoder. It performs these functions:
- Latches the multiplexed address on ALE.
- Registers the RD/WR/INTA strobes and the write data onto a demultiplexed bus.
- Inserts programmable wait states by holding READY low, with separate counts for memory and I/O.
- Returns registered read data to the CPU.

It sits directly upstream of the system bus, which consumes its address, strobes, IO/M and write data.

## Interface
- `MEM_WAIT`, default 0: wait states inserted on memory cycles (0..15).
- `IO_WAIT`, default 2: wait states inserted on I/O and INTA cycles (0..15).

Clock and reset are decided as follows: one clock; reset is synchronous and active-high.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_ale` in 1: address latch enable from the CPU.
- `cpu_ad` in 8: multiplexed AD7..AD0 (address in the ALE cycle, write data afterwards).
- `cpu_a_hi` in 12: A19..A8.
- `cpu_iom` in 1: 1 = I/O, 0 = memory.
- `cpu_rd_n`, `cpu_wr_n`, `cpu_inta_n` in 1 each: CPU strobes, active low.
- `cpu_ready` out 1: READY to the CPU.
- `cpu_rd_data` out 8: registered read/INTA data to the CPU.
- `bus_addr` out 20: latched address.
- `bus_iom` out 1: latched IO/M.
- `bus_rd_n`, `bus_wr_n`, `bus_inta_n` out 1 each: registered strobes.
- `bus_dout` out 8: write data.
- `bus_din` in 8: read data from the system bus.
- `bus_err` out 1: sticky protocol-error flag.

## Operation
States: IDLE, ADDR, CMD.

- **IDLE**
  - When `cpu_ale`=1: latch `bus_addr` <= {`cpu_a_hi`, `cpu_ad`} and `bus_iom` <= `cpu_iom`; go to ADDR.
  - A strobe seen while in IDLE is ignored.
- **ADDR**
  - Waits for exactly one strobe to go low.
  - On `cpu_rd_n`=0: `bus_rd_n` <= 0.
  - On `cpu_wr_n`=0: `bus_wr_n` <= 0 and `bus_dout` <= `cpu_ad`.
  - On `cpu_inta_n`=0: `bus_inta_n` <= 0.
  - On any of the above: load the counter with W (W = `IO_WAIT` if `bus_iom` or INTA, else `MEM_WAIT`); `cpu_ready` <= (W==0); go to CMD.
  - If more than one strobe is low in the same cycle: `bus_err` <= 1, no bus strobe, go to IDLE.
  - A new `cpu_ale` in ADDR relatches the address and stays in ADDR.
- **CMD**
  - If cnt>0, cnt <= cnt-1. `cpu_ready` <= (cnt<=1).
  - On a read or INTA, `cpu_rd_data` <= `bus_din` every cycle.
  - When all CPU strobes are high: deassert every bus strobe, `cpu_ready` <= 1, go to IDLE.
  - `cpu_ale`=1 in CMD is a protocol error: `bus_err` <= 1, strobes deasserted, go to IDLE. The address is not relatched.
- **Counter:** 4-bit and saturating at 0. Parameters greater than 15 are a synthesis-time error.
- **Output hold:** `bus_addr`, `bus_iom` and `bus_dout` hold their value after the cycle ends until the next latch.
- **`bus_err`:** cleared only by `rst`.

## Timing
- All outputs are registered.
- Reset values:
  - `bus_addr`=0, `bus_iom`=0, `bus_dout`=0
  - `bus_rd_n`=`bus_wr_n`=`bus_inta_n`=1
  - `cpu_ready`=1, `cpu_rd_data`=0, `bus_err`=0
  - state = IDLE, cnt=0
- Reset in the middle of a cycle deasserts all strobes on the next edge. No partial write is re-issued.
- ALE sampled at edge k: `bus_addr` is valid after edge k.
- Strobe sampled low at edge n: the bus strobe is low after edge n, and `cpu_ready` is low after edge n when W>0.
- `cpu_ready` goes high after edge n+W. The last `bus_din` sampled before strobe release is what `cpu_rd_data` holds.
- Strobe release sampled at edge m: bus strobes are high after edge m. That is one cycle of latency in each direction.
- Bus strobe width is at least W+1 cycles.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - state enum `bus_state_t` {IDLE, ADDR, CMD}
  - `WAIT_W`=4
  - reset-value constants for the strobes
- One sub-module, `bus_wait_timer`:
  - Inputs: load, load value, decrement enable.
  - Outputs: count and `last` (cnt<=1).
  - The main module keeps the FSM, latches and data registers.

## Test plan
- **Memory read, `MEM_WAIT`=0:**
  - Stimulus: ALE with A=0xFC012 (`cpu_a_hi`=0xFC0, `cpu_ad`=0x12), then `cpu_rd_n` low for 3 cycles, `bus_din`=0xA5.
  - Required: `bus_addr`=0xFC012 and `bus_rd_n` low 3 cycles, one cycle delayed; `cpu_ready` never low; `cpu_rd_data`=0xA5.
- **I/O write, `IO_WAIT`=2:**
  - Stimulus: ALE with A=0x00021, iom=1, `cpu_ad`=0x13 when `cpu_wr_n` falls.
  - Required: `bus_dout`=0x13; `cpu_ready` low exactly 2 cycles; `bus_wr_n` deasserts the cycle after `cpu_wr_n` rises.
- **INTA:**
  - Stimulus: `cpu_inta_n` low, `bus_din`=0x08.
  - Required: `bus_inta_n` low; `IO_WAIT` wait states; `cpu_rd_data`=0x08.
- **Protocol errors:**
  - Stimulus: `cpu_rd_n` and `cpu_wr_n` low together in ADDR.
  - Required: no bus strobe; `bus_err`=1 and sticky; the next clean cycle completes normally.
  - Stimulus: ALE asserted in CMD.
  - Required: `bus_err`=1; strobes released; address unchanged.
- **Reset mid-cycle:**
  - Stimulus: `rst` pulsed during CMD of an I/O read with `IO_WAIT`=5.
  - Required: every output at its reset value after that edge; `cpu_ready`=1; state IDLE.
